retry_start: RTL and testbench

- Upstream partner of retry_end in the time-redundancy retry pair.
- Assigns a wrapping ID to every operation entering the (pipelined) combinational process.
- Stores each operation's data in an ID-indexed buffer.
- Re-issues the stored data when retry_end reports a failed result over the retry connection; retries take priority over new operations.

---
 rtl/retry_start.sv | 127 ++++++++++++
 tb/tb_retry_start.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/retry_start.sv
// Upstream half of the time-redundancy retry pair: tags each new operation with a
// wrapping ID, keeps its payload in an ID-indexed buffer and replays it on request.

module retry_start_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic retry_valid_i,
  input logic retry_ready_o
);

  // A retry request that is held off must stay asserted until it is accepted
  retry_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (retry_valid_i && !retry_ready_o) |=> retry_valid_i)
    else $error("retry_start: retry_valid_i dropped while held off");

endmodule

module retry_start #(
  parameter type DataType = logic,
  parameter int  IDSize   = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic [IDSize-1:0] retry_id_i,
  input  logic              retry_valid_i,
  output logic              retry_ready_o
);

  localparam int Depth = 2**IDSize;

  logic [IDSize-1:0] id_r;
  logic [IDSize-1:0] rb_id_r;
  logic              rb_valid_r;
  logic              rb_valid_s;
  logic              new_hs_s;
  logic              retry_acc_s;
  DataType           mem_r [Depth];

  // Retries are only taken while the holding register is empty, so the
  // acceptance signal depends on registered state alone.
  assign retry_acc_s = retry_valid_i && !rb_valid_r;
  assign new_hs_s    = !rb_valid_r && valid_i && ready_i;

  // Replay-buffer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rb_valid_r <= 1'b0;
    end else begin
      rb_valid_r <= rb_valid_s;
    end
  end

  // Replay-buffer next state: fill on accepted retry, drain on replay handshake
  always_comb begin
    rb_valid_s = rb_valid_r;
    if (rb_valid_r) begin
      if (ready_i) begin
        rb_valid_s = 1'b0;
      end else begin
        rb_valid_s = 1'b1;
      end
    end else begin
      if (retry_valid_i) begin
        rb_valid_s = 1'b1;
      end else begin
        rb_valid_s = 1'b0;
      end
    end
  end

  // Output mux: replay the stored op or pass the upstream op through
  always_comb begin
    valid_o       = valid_i;
    data_o        = data_i;
    id_o          = id_r;
    ready_o       = ready_i;
    retry_ready_o = !rb_valid_r;
    if (rb_valid_r) begin
      valid_o = 1'b1;
      data_o  = mem_r[rb_id_r];
      id_o    = rb_id_r;
      ready_o = 1'b0;
    end else begin
      valid_o = valid_i;
      data_o  = data_i;
      id_o    = id_r;
      ready_o = ready_i;
    end
  end

  // ID counter and retry ID capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_r    <= {IDSize{1'b0}};
      rb_id_r <= {IDSize{1'b0}};
    end else begin
      if (new_hs_s) begin
        id_r <= id_r + IDSize'(1);
      end
      if (retry_acc_s) begin
        rb_id_r <= retry_id_i;
      end
    end
  end

  // Payload buffer, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (new_hs_s) begin
      mem_r[id_r] <= data_i;
    end
  end

  retry_start_chk u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .retry_valid_i (retry_valid_i),
    .retry_ready_o (retry_ready_o)
  );

endmodule

// File: tb/tb_retry_start.sv
// Directed, table-driven bench for retry_start (IDSize=2, byte payload).

module tb_retry_start;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic [1:0] id_o;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] retry_id_i;
  logic       retry_valid_i;
  logic       retry_ready_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       vi;
    logic [7:0] di;
    logic       ri;
    logic       rv;
    logic [1:0] rid;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] eid;
    logic       ero;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  retry_start #(.DataType(logic [7:0]), .IDSize(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_o        (data_o),
    .id_o          (id_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .retry_id_i    (retry_id_i),
    .retry_valid_i (retry_valid_i),
    .retry_ready_o (retry_ready_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic rst, logic vi, logic [7:0] di, logic ri, logic rv,
                              logic [1:0] rid, logic ev, logic [7:0] ed, logic [1:0] eid,
                              logic ero, logic err);
    vec_t v;
    v.rst = rst; v.vi = vi; v.di = di; v.ri = ri; v.rv = rv; v.rid = rid;
    v.ev = ev; v.ed = ed; v.eid = eid; v.ero = ero; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic ev, input logic [7:0] ed,
                           input logic [1:0] eid, input logic ero, input logic err);
    chk({tag, ".valid_o"}, idx, {7'd0, valid_o}, {7'd0, ev});
    chk({tag, ".data_o"}, idx, data_o, ed);
    chk({tag, ".id_o"}, idx, {6'd0, id_o}, {6'd0, eid});
    chk({tag, ".ready_o"}, idx, {7'd0, ready_o}, {7'd0, ero});
    chk({tag, ".retry_ready_o"}, idx, {7'd0, retry_ready_o}, {7'd0, err});
  endtask

  initial begin
    // Phase 1: five back-to-back ops, IDs wrap 0,1,2,3,0
    //            rst   vi    di     ri    rv    rid    ev    ed     eid    ero   err
    vecs.push_back(mk(1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 2'd0, 1'b1, 8'hA1, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 2'd0, 1'b1, 8'hB2, 2'd1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 2'd0, 1'b1, 8'hC3, 2'd2, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hD4, 1'b1, 1'b0, 2'd0, 1'b1, 8'hD4, 2'd3, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hE5, 1'b1, 1'b0, 2'd0, 1'b1, 8'hE5, 2'd0, 1'b1, 1'b1));
    // Phase 2 (fresh reset): A,B then retry id0 alongside B; replay; C with retry id0
    vecs.push_back(mk(1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 2'd0, 1'b1, 8'hA1, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 2'd0, 1'b1, 8'hB2, 2'd1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 2'd0, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 2'd0, 1'b1, 8'hC3, 2'd2, 1'b1, 1'b1));
    // Replay of A stalled 3 cycles; second retry (id1) held off meanwhile
    vecs.push_back(mk(1'b0, 1'b1, 8'hD4, 1'b0, 1'b0, 2'd0, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hD4, 1'b0, 1'b1, 2'd1, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hD4, 1'b0, 1'b1, 2'd1, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hD4, 1'b1, 1'b1, 2'd1, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0));
    // Held retry accepted with D's handshake (id3), B replayed next cycle
    vecs.push_back(mk(1'b0, 1'b1, 8'hD4, 1'b1, 1'b1, 2'd1, 1'b1, 8'hD4, 2'd3, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hE5, 1'b1, 1'b0, 2'd0, 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0));
    // ID wrapped to 0; E overwrites slot 0
    vecs.push_back(mk(1'b0, 1'b0, 8'hE5, 1'b1, 1'b0, 2'd0, 1'b0, 8'hE5, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hE5, 1'b1, 1'b0, 2'd0, 1'b1, 8'hE5, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'hE5, 1'b0, 1'b1, 2'd2, 1'b0, 8'hE5, 2'd1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'hE5, 1'b1, 1'b0, 2'd0, 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 2'd0, 1'b0, 8'h5A, 2'd1, 1'b1, 1'b1));
    // Replay of slot 0 (now E) left pending for the reset sequence below
    vecs.push_back(mk(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1, 8'hE5, 2'd0, 1'b0, 1'b0));

    rst_ni = 1'b0; valid_i = 1'b0; data_i = 8'h3C; ready_i = 1'b1;
    retry_valid_i = 1'b0; retry_id_i = 2'd0;
    @(negedge clk_i);
    #1;
    check_all("reset", -1, 1'b0, 8'h3C, 2'd0, 1'b1, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
      end
      valid_i = vecs[i].vi; data_i = vecs[i].di; ready_i = vecs[i].ri;
      retry_valid_i = vecs[i].rv; retry_id_i = vecs[i].rid;
      #1;
      check_all("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].eid, vecs[i].ero, vecs[i].err);
      if (i < vecs.size() - 1) begin
        @(posedge clk_i);
        @(negedge clk_i);
      end
    end

    // Asynchronous reset in the middle of a pending replay
    #2;
    valid_i = 1'b0; data_i = 8'h77; ready_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    check_all("async_rst", 0, 1'b0, 8'h77, 2'd0, 1'b1, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_all("after_rst", 0, 1'b0, 8'h77, 2'd0, 1'b1, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b1; data_i = 8'h88;
    #1;
    check_all("after_rst", 1, 1'b1, 8'h88, 2'd0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
